// File: rtl/register_tree_pq_if.sv
// Handshake bundle for register_tree_pq: command inputs, root output and status flags.
// When REGISTER_TREE_ERR_EN is defined the bundle also carries the sticky o_err flags.
interface register_tree_pq_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  i_enqueue;
  logic                  i_dequeue;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_ready;
  logic                  o_empty;
  logic                  o_full;
`ifdef REGISTER_TREE_ERR_EN
  logic [2:0]            o_err;

  modport master (
    output i_enqueue, i_dequeue, i_data,
    input  o_data, o_ready, o_empty, o_full, o_err
  );

  modport slave (
    input  i_enqueue, i_dequeue, i_data,
    output o_data, o_ready, o_empty, o_full, o_err
  );
`else
  modport master (
    output i_enqueue, i_dequeue, i_data,
    input  o_data, o_ready, o_empty, o_full
  );

  modport slave (
    input  i_enqueue, i_dequeue, i_data,
    output o_data, o_ready, o_empty, o_full
  );
`endif
endinterface

// File: rtl/register_tree_pq.sv
// Max-priority queue held in a flat register tree (node k has children 2k+1 and 2k+2).
// Commands are taken in IDLE; SETTLE then runs LEVELS+1 cycles of odd/even-level
// compare-and-swap so one sift-up or sift-down can cross the whole depth.
// Optional feature macro: REGISTER_TREE_ERR_EN adds sticky o_err flags to the interface.
module register_tree_pq #(
  parameter int QUEUE_SIZE = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  register_tree_pq_if.slave   pq
);

  localparam int LEVELS = $clog2(QUEUE_SIZE + 1);
  localparam int SW     = $clog2(QUEUE_SIZE + 1);
  localparam int NI     = (QUEUE_SIZE - 1) / 2;
  localparam int CW     = $clog2(LEVELS + 2);

  if (QUEUE_SIZE != (2 ** LEVELS) - 1) begin : g_bad_size
    $error("register_tree_pq: QUEUE_SIZE must equal 2**LEVELS-1");
  end

  function automatic int level_of(input int k);
    return $clog2(k + 2) - 1;
  endfunction

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  logic [DATA_WIDTH-1:0] node_q [QUEUE_SIZE];
  logic [DATA_WIDTH-1:0] node_d [QUEUE_SIZE];
  logic [SW-1:0]         size_q, size_d;
  logic [SW-1:0]         size_m1;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  parity_q, parity_d;

  logic [NI-1:0]         swap_l;
  logic [NI-1:0]         swap_r;
  logic [NI-1:0]         fire;

  logic                  is_full;
  logic                  is_empty;

  assign is_full  = (size_q == SW'(QUEUE_SIZE));
  assign is_empty = (size_q == '0);
  assign size_m1  = size_q - SW'(1);

  // One comparator per internal node: pick the larger child (left wins ties) and
  // request a swap only when the parent is strictly smaller than it.
  for (genvar k = 0; k < NI; k++) begin : g_cmp
    localparam bit LVL_PAR = 1'((level_of(k) % 2));
    logic right_bigger;
    assign right_bigger = node_q[2*k+2] > node_q[2*k+1];
    assign swap_l[k]    = !right_bigger && (node_q[k] < node_q[2*k+1]);
    assign swap_r[k]    =  right_bigger && (node_q[k] < node_q[2*k+2]);
    assign fire[k]      = (parity_q == LVL_PAR);
  end

  // Next-state logic: accept commands in IDLE, apply comparator results in SETTLE.
  always_comb begin
    node_d   = node_q;
    size_d   = size_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    case (state_q)
      IDLE: begin
        if (pq.i_enqueue && (!pq.i_dequeue || is_empty)) begin
          if (!is_full) begin
            node_d[size_q] = pq.i_data;
            size_d         = size_q + SW'(1);
            state_d        = SETTLE;
            cnt_d          = CW'(LEVELS + 1);
            parity_d       = 1'b0;
          end
        end else if (pq.i_enqueue && pq.i_dequeue) begin
          node_d[0] = pq.i_data;
          state_d   = SETTLE;
          cnt_d     = CW'(LEVELS + 1);
          parity_d  = 1'b0;
        end else if (pq.i_dequeue && !is_empty) begin
          node_d[0]       = node_q[size_m1];
          node_d[size_m1] = '0;
          size_d          = size_m1;
          state_d         = SETTLE;
          cnt_d           = CW'(LEVELS + 1);
          parity_d        = 1'b0;
        end
      end
      SETTLE: begin
        for (int k = 0; k < NI; k++) begin
          if (fire[k]) begin
            if (swap_l[k]) begin
              node_d[k]     = node_q[2*k+1];
              node_d[2*k+1] = node_q[k];
            end else if (swap_r[k]) begin
              node_d[k]     = node_q[2*k+2];
              node_d[2*k+2] = node_q[k];
            end
          end
        end
        parity_d = ~parity_q;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards all contents, including a settle in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < QUEUE_SIZE; k++) begin
        node_q[k] <= '0;
      end
      size_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      node_q   <= node_d;
      size_q   <= size_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
    end
  end

  assign pq.o_data  = node_q[0];
  assign pq.o_ready = (state_q == IDLE);
  assign pq.o_empty = is_empty;
  assign pq.o_full  = is_full;

`ifdef REGISTER_TREE_ERR_EN
  logic [2:0] err_q, err_d;

  // Sticky error flags: full drop, empty drop, command while busy.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE) begin
      if (pq.i_enqueue && !pq.i_dequeue && is_full) begin
        err_d[0] = 1'b1;
      end
      if (pq.i_dequeue && !pq.i_enqueue && is_empty) begin
        err_d[1] = 1'b1;
      end
    end else if (pq.i_enqueue || pq.i_dequeue) begin
      err_d[2] = 1'b1;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign pq.o_err = err_q;
`endif

endmodule

// File: tb/tb_register_tree_pq.sv
// Directed testbench for register_tree_pq (QUEUE_SIZE=15, DATA_WIDTH=16) with a
// sorted-list style reference model and a heap-order check after every operation.
module tb_register_tree_pq;

  logic clk = 1'b0;
  logic rst;
  int   check_count = 0;
  int   pass_count  = 0;
  int   model[$];
  int   busy;

  register_tree_pq_if #(.DATA_WIDTH(16)) bus ();

  register_tree_pq #(
    .QUEUE_SIZE(15),
    .DATA_WIDTH(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .pq   (bus)
  );

  always #5 clk = ~clk;

  // Guard against a hung simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    check_count++;
    if (observed == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int modelMax();
    int m = 0;
    foreach (model[i]) if (model[i] > m) m = model[i];
    return m;
  endfunction

  task automatic removeMax();
    int idx = 0;
    foreach (model[i]) if (model[i] > model[idx]) idx = i;
    model.delete(idx);
  endtask

  task automatic checkHeap();
    bit ok = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (dut.node_q[k] < dut.node_q[2*k+1] || dut.node_q[k] < dut.node_q[2*k+2]) ok = 1'b0;
    end
    checkOutput("heap_order", longint'(ok), 1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_root"},  bus.o_data, modelMax());
    checkOutput({tag, "_empty"}, bus.o_empty, (model.size() == 0) ? 1 : 0);
    checkOutput({tag, "_full"},  bus.o_full, (model.size() == 15) ? 1 : 0);
    checkHeap();
  endtask

  task automatic waitReady(input string tag);
    int guard = 0;
    while (!bus.o_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.o_ready) checkOutput({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Issue one command in IDLE, measure the busy window and compare with the model.
  task automatic applyStimulus(input logic enq, input logic deq, input logic [15:0] data,
                               output int busy_cycles);
    int  sz;
    bit  accepted;
    waitReady("pre_cmd");
    sz       = model.size();
    accepted = 1'b0;
    bus.i_enqueue = enq;
    bus.i_dequeue = deq;
    bus.i_data    = data;
    @(posedge clk); #1;
    bus.i_enqueue = 1'b0;
    bus.i_dequeue = 1'b0;
    busy_cycles = 0;
    while (!bus.o_ready && busy_cycles < 50) begin
      busy_cycles++;
      @(posedge clk); #1;
    end
    if (enq && (!deq || sz == 0)) begin
      if (sz < 15) begin
        model.push_back(int'(data));
        accepted = 1'b1;
      end
    end else if (enq && deq) begin
      removeMax();
      model.push_back(int'(data));
      accepted = 1'b1;
    end else if (deq && sz > 0) begin
      removeMax();
      accepted = 1'b1;
    end
    checkOutput("busy_cycles", busy_cycles, accepted ? 5 : 0);
    checkIdle("op");
  endtask

  initial begin
    rst = 1'b1;
    bus.i_enqueue = 1'b0;
    bus.i_dequeue = 1'b0;
    bus.i_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data",  bus.o_data, 0);
    checkOutput("reset_ready", bus.o_ready, 1);
    checkOutput("reset_empty", bus.o_empty, 1);
    checkOutput("reset_full",  bus.o_full, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] test 1: enqueue 5,9,3,12");
    applyStimulus(1, 0, 16'd5, busy);  checkOutput("t1_root5", bus.o_data, 5);
    applyStimulus(1, 0, 16'd9, busy);  checkOutput("t1_root9", bus.o_data, 9);
    applyStimulus(1, 0, 16'd3, busy);  checkOutput("t1_root9b", bus.o_data, 9);
    applyStimulus(1, 0, 16'd12, busy); checkOutput("t1_root12", bus.o_data, 12);

    $display("[TB] test 2: four dequeues");
    applyStimulus(0, 1, 16'd0, busy); checkOutput("t2_root9", bus.o_data, 9);
    applyStimulus(0, 1, 16'd0, busy); checkOutput("t2_root5", bus.o_data, 5);
    applyStimulus(0, 1, 16'd0, busy); checkOutput("t2_root3", bus.o_data, 3);
    applyStimulus(0, 1, 16'd0, busy);
    checkOutput("t2_empty", bus.o_empty, 1);
    checkOutput("t2_root0", bus.o_data, 0);

    $display("[TB] test 3: fill ascending, then overflow");
    for (int v = 1; v <= 15; v++) begin
      applyStimulus(1, 0, 16'(v), busy);
    end
    checkOutput("t3_full", bus.o_full, 1);
    checkOutput("t3_root15", bus.o_data, 15);
    applyStimulus(1, 0, 16'd99, busy);
    checkOutput("t3_drop_root", bus.o_data, 15);
`ifdef REGISTER_TREE_ERR_EN
    checkOutput("t3_err", bus.o_err, 3'b001);
`endif

    $display("[TB] test 4: replace on full and on empty");
    applyStimulus(1, 1, 16'd7, busy);
    checkOutput("t4_root14", bus.o_data, 14);
    checkOutput("t4_full", bus.o_full, 1);
    for (int n = 0; n < 15; n++) begin
      applyStimulus(0, 1, 16'd0, busy);
    end
    checkOutput("t4_drained", bus.o_empty, 1);
    applyStimulus(1, 1, 16'd4, busy);
    checkOutput("t4_root4", bus.o_data, 4);
    checkOutput("t4_notempty", bus.o_empty, 0);

    $display("[TB] test 5: commands while busy are ignored");
    waitReady("t5");
    bus.i_enqueue = 1'b1;
    bus.i_data    = 16'd2;
    @(posedge clk); #1;
    model.push_back(2);
    checkOutput("t5_busy", bus.o_ready, 0);
    bus.i_data = 16'd8;
    repeat (3) @(posedge clk);
    #1;
    bus.i_enqueue = 1'b0;
    waitReady("t5_settle");
    checkIdle("t5");
    checkOutput("t5_root4", bus.o_data, 4);
`ifdef REGISTER_TREE_ERR_EN
    checkOutput("t5_err_busy", bus.o_err, 3'b101);
`endif
    applyStimulus(0, 1, 16'd0, busy); checkOutput("t5_root2", bus.o_data, 2);
    applyStimulus(0, 1, 16'd0, busy); checkOutput("t5_empty", bus.o_empty, 1);
    applyStimulus(0, 1, 16'd0, busy); checkOutput("t5_deq_empty_root", bus.o_data, 0);
`ifdef REGISTER_TREE_ERR_EN
    checkOutput("t5_err_empty", bus.o_err, 3'b111);
`endif

    $display("[TB] test 6: reset in the middle of a settle");
    applyStimulus(1, 0, 16'd20, busy);
    waitReady("t6");
    bus.i_enqueue = 1'b1;
    bus.i_data    = 16'd10;
    @(posedge clk); #1;
    bus.i_enqueue = 1'b0;
    @(posedge clk); #2;
    checkOutput("t6_in_settle", bus.o_ready, 0);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_empty", bus.o_empty, 1);
    checkOutput("t6_rst_data",  bus.o_data, 0);
    checkOutput("t6_rst_ready", bus.o_ready, 1);
`ifdef REGISTER_TREE_ERR_EN
    checkOutput("t6_rst_err", bus.o_err, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    model.delete();
    @(posedge clk); #1;
    applyStimulus(1, 0, 16'd6, busy);
    checkOutput("t6_root6", bus.o_data, 6);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
